// File: rtl/register_file.sv
// GPO command decoder and GPI read-back bridge between the soft
// processor and the Tx/Rx/BER/log-memory datapath.
module register_file #(
    parameter int NB_ADDR_MEM = 15
) (
    input  logic                   clk,
    input  logic                   i_rst,
    input  logic [31:0]            i_gpo,
    input  logic [31:0]            i_data_log_from_mem,
    input  logic                   i_mem_full,
    input  logic [63:0]            i_ber_samp_I,
    input  logic [63:0]            i_ber_samp_Q,
    input  logic [63:0]            i_ber_error_I,
    input  logic [63:0]            i_ber_error_Q,
    output logic [31:0]            o_gpi,
    output logic                   o_rst,
    output logic                   o_enbTx,
    output logic                   o_enbRx,
    output logic [1:0]             o_phase_sel,
    output logic                   o_run_log,
    output logic                   o_read_log,
    output logic [NB_ADDR_MEM-1:0] o_addr_log_to_mem
);

    localparam logic [7:0] CMD_RESET    = 8'd0;
    localparam logic [7:0] CMD_EN_TX    = 8'd1;
    localparam logic [7:0] CMD_EN_RX    = 8'd2;
    localparam logic [7:0] CMD_PH_SEL   = 8'd3;
    localparam logic [7:0] CMD_RUN_MEM  = 8'd4;
    localparam logic [7:0] CMD_READ_MEM = 8'd5;
    localparam logic [7:0] CMD_ADDR_MEM = 8'd6;
    localparam logic [7:0] CMD_BER_S_I  = 8'd7;
    localparam logic [7:0] CMD_BER_S_Q  = 8'd8;
    localparam logic [7:0] CMD_BER_E_I  = 8'd9;
    localparam logic [7:0] CMD_BER_E_Q  = 8'd10;
    localparam logic [7:0] CMD_BER_H    = 8'd11;
    localparam logic [7:0] CMD_MEM_FULL = 8'd12;

    logic [7:0]  cmd;
    logic [22:0] data;
    logic        enb_prev;
    logic        strobe;
    logic        gpi_mem;
    logic [31:0] ber_high;

    assign cmd    = i_gpo[31:24];
    assign data   = i_gpo[22:0];
    assign strobe = i_gpo[23] & ~enb_prev;

    // Data bits above the address width carry no meaning for any command.
    if (NB_ADDR_MEM < 23) begin : g_unused
        logic unused_data;
        assign unused_data = ^data[22:NB_ADDR_MEM];
    end

    // Rising edge of the enable bit executes one command; memory source
    // keeps o_gpi following the log memory to hide its read latency.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            enb_prev          <= 1'b0;
            gpi_mem           <= 1'b0;
            ber_high          <= '0;
            o_gpi             <= '0;
            o_rst             <= 1'b0;
            o_enbTx           <= 1'b0;
            o_enbRx           <= 1'b0;
            o_phase_sel       <= '0;
            o_run_log         <= 1'b0;
            o_read_log        <= 1'b0;
            o_addr_log_to_mem <= '0;
        end else begin
            enb_prev  <= i_gpo[23];
            o_run_log <= 1'b0;
            if (gpi_mem) begin
                o_gpi <= i_data_log_from_mem;
            end
            if (strobe) begin
                case (cmd)
                    CMD_RESET:  o_rst       <= data[0];
                    CMD_EN_TX:  o_enbTx     <= data[0];
                    CMD_EN_RX:  o_enbRx     <= data[0];
                    CMD_PH_SEL: o_phase_sel <= data[1:0];
                    CMD_RUN_MEM: begin
                        o_run_log  <= 1'b1;
                        o_read_log <= 1'b0;
                    end
                    CMD_READ_MEM: begin
                        o_read_log        <= 1'b1;
                        o_addr_log_to_mem <= data[NB_ADDR_MEM-1:0];
                        gpi_mem           <= 1'b1;
                        o_gpi             <= i_data_log_from_mem;
                    end
                    CMD_ADDR_MEM: begin
                        o_addr_log_to_mem <= data[NB_ADDR_MEM-1:0];
                        gpi_mem           <= 1'b1;
                        o_gpi             <= i_data_log_from_mem;
                    end
                    CMD_BER_S_I: begin
                        o_gpi    <= i_ber_samp_I[31:0];
                        ber_high <= i_ber_samp_I[63:32];
                        gpi_mem  <= 1'b0;
                    end
                    CMD_BER_S_Q: begin
                        o_gpi    <= i_ber_samp_Q[31:0];
                        ber_high <= i_ber_samp_Q[63:32];
                        gpi_mem  <= 1'b0;
                    end
                    CMD_BER_E_I: begin
                        o_gpi    <= i_ber_error_I[31:0];
                        ber_high <= i_ber_error_I[63:32];
                        gpi_mem  <= 1'b0;
                    end
                    CMD_BER_E_Q: begin
                        o_gpi    <= i_ber_error_Q[31:0];
                        ber_high <= i_ber_error_Q[63:32];
                        gpi_mem  <= 1'b0;
                    end
                    CMD_BER_H: begin
                        o_gpi   <= ber_high;
                        gpi_mem <= 1'b0;
                    end
                    CMD_MEM_FULL: begin
                        o_gpi   <= {31'b0, i_mem_full};
                        gpi_mem <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file: stimulus queues expected output
// snapshots, a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_register_file;

    localparam int NB = 15;

    logic          clk = 1'b0;
    logic          i_rst;
    logic [31:0]   i_gpo;
    logic [31:0]   i_data_log_from_mem;
    logic          i_mem_full;
    logic [63:0]   i_ber_samp_I;
    logic [63:0]   i_ber_samp_Q;
    logic [63:0]   i_ber_error_I;
    logic [63:0]   i_ber_error_Q;
    logic [31:0]   o_gpi;
    logic          o_rst;
    logic          o_enbTx;
    logic          o_enbRx;
    logic [1:0]    o_phase_sel;
    logic          o_run_log;
    logic          o_read_log;
    logic [NB-1:0] o_addr_log_to_mem;

    register_file #(.NB_ADDR_MEM(NB)) dut (
        .clk                 (clk),
        .i_rst               (i_rst),
        .i_gpo               (i_gpo),
        .i_data_log_from_mem (i_data_log_from_mem),
        .i_mem_full          (i_mem_full),
        .i_ber_samp_I        (i_ber_samp_I),
        .i_ber_samp_Q        (i_ber_samp_Q),
        .i_ber_error_I       (i_ber_error_I),
        .i_ber_error_Q       (i_ber_error_Q),
        .o_gpi               (o_gpi),
        .o_rst               (o_rst),
        .o_enbTx             (o_enbTx),
        .o_enbRx             (o_enbRx),
        .o_phase_sel         (o_phase_sel),
        .o_run_log           (o_run_log),
        .o_read_log          (o_read_log),
        .o_addr_log_to_mem   (o_addr_log_to_mem)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        string       name;
        logic [53:0] exp;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    logic [31:0]   e_gpi;
    logic          e_rst, e_tx, e_rx, e_run, e_read;
    logic [1:0]    e_ph;
    logic [NB-1:0] e_addr;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every queued expectation due in this cycle.
    always @(negedge clk) begin
        logic [53:0] act;
        exp_t        e;
        act = {o_gpi, o_rst, o_enbTx, o_enbRx, o_phase_sel,
               o_run_log, o_read_log, o_addr_log_to_mem};
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            checks++;
            if (act !== e.exp) begin
                failures++;
                $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
            end
        end
    end

    task automatic model_zero();
        e_gpi = '0; e_rst = 0; e_tx = 0; e_rx = 0;
        e_ph = '0; e_run = 0; e_read = 0; e_addr = '0;
    endtask

    task automatic push(input string nm, input int lag);
        exp_t e;
        e.cyc  = cyc + lag;
        e.name = nm;
        e.exp  = {e_gpi, e_rst, e_tx, e_rx, e_ph, e_run, e_read, e_addr};
        sb.push_back(e);
    endtask

    // Idle one edge with enable low, then strobe; returns #1 after the
    // executing edge with enable already dropped.
    task automatic issue(input logic [7:0] c, input logic [22:0] d);
        @(posedge clk); #1;
        i_gpo = {c, 1'b1, d};
        @(posedge clk); #1;
        i_gpo[23] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        i_rst = 1; i_gpo = '0; i_data_log_from_mem = '0; i_mem_full = 0;
        i_ber_samp_I  = 64'h0AFB2344_53BCDE21;
        i_ber_samp_Q  = 64'h10AE2342_21349208;
        i_ber_error_I = 64'h0211FD3A_2DE25674;
        i_ber_error_Q = 64'h11334564_23DCDCA1;
        model_zero();
        repeat (3) @(posedge clk);
        #1 push("reset_state", 0);
        i_rst = 0;

        issue(8'd0, 23'd1); e_rst = 1; push("cmd_reset", 0);
        issue(8'd1, 23'd1); e_tx = 1;  push("cmd_en_tx", 0);
        issue(8'd2, 23'd1); e_rx = 1;  push("cmd_en_rx", 0);
        for (int p = 0; p < 4; p++) begin
            issue(8'd3, 23'(p)); e_ph = 2'(p); push("ph_sel", 0);
        end

        @(posedge clk); #1;
        i_gpo = {8'd3, 1'b1, 23'd1};
        @(posedge clk); #1;
        e_ph = 2'd1; push("hold_first", 0);
        i_gpo = {8'd3, 1'b1, 23'd2};
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1; push("hold_no_repeat", 0);
        end
        i_gpo[23] = 1'b0;

        issue(8'd12, 23'd0); e_gpi = 32'h0; push("mem_full_0", 0);
        i_mem_full = 1;
        issue(8'd12, 23'd0); e_gpi = 32'h1; push("mem_full_1", 0);
        issue(8'd11, 23'd0); e_gpi = 32'h0; push("ber_h_init", 0);

        issue(8'd7, 23'd0);  e_gpi = 32'h53BCDE21; push("ber_s_i_lo", 0);
        i_ber_samp_I = 64'hFFFFFFFF_00000000;
        issue(8'd11, 23'd0); e_gpi = 32'h0AFB2344; push("ber_s_i_hi", 0);
        issue(8'd8, 23'd0);  e_gpi = 32'h21349208; push("ber_s_q_lo", 0);
        issue(8'd11, 23'd0); e_gpi = 32'h10AE2342; push("ber_s_q_hi", 0);
        issue(8'd9, 23'd0);  e_gpi = 32'h2DE25674; push("ber_e_i_lo", 0);
        issue(8'd11, 23'd0); e_gpi = 32'h0211FD3A; push("ber_e_i_hi", 0);
        issue(8'd10, 23'd0); e_gpi = 32'h23DCDCA1; push("ber_e_q_lo", 0);
        issue(8'd11, 23'd0); e_gpi = 32'h11334564; push("ber_e_q_hi", 0);

        issue(8'd13, 23'h7FFFFF);  push("cmd13_noop", 0);
        issue(8'd255, 23'h7FFFFF); push("cmd255_noop", 0);

        i_data_log_from_mem = 32'h0000AF0F;
        issue(8'd5, 23'h35EB1C);
        e_read = 1; e_addr = 15'h6B1C; e_gpi = 32'h0000AF0F;
        push("read_mem", 1);
        @(posedge clk); #1;
        i_data_log_from_mem = 32'h12345678;
        e_gpi = 32'h12345678; push("mem_track", 1);
        @(posedge clk); #1;

        issue(8'd6, 23'h07FFFF);
        e_addr = 15'h7FFF; push("addr_mem", 0);
        issue(8'd4, 23'd0);
        e_run = 1; e_read = 0; push("run_pulse", 0);
        e_run = 0; push("run_pulse_end", 1);

        issue(8'd12, 23'd0); e_gpi = 32'h1; push("mem_src_off", 0);
        i_data_log_from_mem = 32'h0;
        push("gpi_static", 1);

        i_data_log_from_mem = 32'hCAFEF00D;
        issue(8'd6, 23'd5);
        e_addr = 15'd5; e_gpi = 32'hCAFEF00D; push("addr_mem_src", 1);
        @(posedge clk); #1;

        i_rst = 1; i_gpo = {8'd3, 1'b1, 23'd2};
        @(posedge clk); #1;
        model_zero(); push("rst_override", 0);
        i_rst = 0; i_gpo[23] = 1'b0;
        i_data_log_from_mem = 32'hDEADBEEF;
        @(posedge clk); #1;
        push("rst_src_none", 0);

        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0",
                     sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
